// File: rtl/imem_loader.sv
// imem_loader: boot loader that writes a checksummed byte-stream image into imem
// and holds the core in reset until a complete, verified image has been loaded.
module imem_loader #(
    parameter int         IMemAddrWidth = 10,
    parameter logic [7:0] SyncByte      = 8'hA5,
    parameter logic       BootHeld      = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic                     imem_we,
    output logic [IMemAddrWidth-1:0] imem_addr,
    output logic [31:0]              imem_wdata,
    output logic                     core_reset,
    output logic                     done,
    output logic                     error
);
    localparam int AW = IMemAddrWidth;

    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;

    state_t          state_q, state_d;
    logic [7:0]      nlo_q, nlo_d, sum_q, sum_d;
    logic [AW:0]     n_q, n_d, w_q, w_d;
    logic [1:0]      bc_q, bc_d;
    logic [23:0]     sh_q, sh_d;
    logic            rdy_q, we_q, we_d, done_q, done_d, err_q, err_d, cr_q, cr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            acc;
    logic [31:0]     len;

    assign acc = rx_valid && rdy_q;
    assign len = {16'd0, rx_data, nlo_q};

    assign rx_ready   = rdy_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_reset = cr_q;
    assign done       = done_q;
    assign error      = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            nlo_q   <= '0;
            sum_q   <= '0;
            n_q     <= '0;
            w_q     <= '0;
            bc_q    <= '0;
            sh_q    <= '0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cr_q    <= BootHeld;
        end else begin
            state_q <= state_d;
            nlo_q   <= nlo_d;
            sum_q   <= sum_d;
            n_q     <= n_d;
            w_q     <= w_d;
            bc_q    <= bc_d;
            sh_q    <= sh_d;
            rdy_q   <= 1'b1;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cr_q    <= cr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        nlo_d   = nlo_q;
        sum_d   = sum_q;
        n_d     = n_q;
        w_d     = w_q;
        bc_d    = bc_q;
        sh_d    = sh_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
        cr_d    = cr_q;
        if (acc) begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (rx_data == SyncByte) begin
                        state_d = LEN_LO;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        cr_d    = 1'b1;
                        w_d     = '0;
                        sum_d   = '0;
                        bc_d    = '0;
                    end
                end
                LEN_LO: begin
                    nlo_d   = rx_data;
                    state_d = LEN_HI;
                end
                LEN_HI: begin
                    n_d = len[AW:0];
                    if (len > (32'd1 << AW)) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        cr_d    = 1'b1;
                    end else begin
                        state_d = (len == 32'd0) ? CSUM : DATA;
                    end
                end
                DATA: begin
                    sum_d = sum_q + rx_data;
                    sh_d  = {rx_data, sh_q[23:8]};
                    bc_d  = bc_q + 2'd1;
                    // fourth byte completes a little-endian word
                    if (bc_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = w_q[AW-1:0];
                        wdata_d = {rx_data, sh_q};
                        w_d     = w_q + 1'b1;
                        if (w_q + 1'b1 == n_q) state_d = CSUM;
                    end
                end
                CSUM: begin
                    if (rx_data == sum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        cr_d    = 1'b0;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        cr_d    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: frame-level reference model for imem_loader; expected writes
// and flags are derived from whole frames, checked every cycle at negedge.
module tb_imem_loader;
    localparam int AW  = 10;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready, imem_we, core_reset, done, error;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    imem_loader #(.IMemAddrWidth(AW), .SyncByte(8'hA5), .BootHeld(1'b1)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_reset(core_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0, n_fail = 0, wr_cnt = 0;
    logic          chk_en = 1'b0, gaps = 1'b0;
    logic          exp_rdy, exp_done, exp_err, exp_cr;
    logic [AW-1:0] ea[$];
    logic [31:0]   ed[$];
    logic [31:0]   wq[$];
    logic [7:0]    frm[$];
    logic [AW-1:0] last_addr;
    logic [31:0]   last_wdata;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("flags{rdy,done,err,cr}", {60'd0, rx_ready, done, error, core_reset},
                  {60'd0, exp_rdy, exp_done, exp_err, exp_cr});
            if (imem_we === 1'b1) begin
                wr_cnt++;
                last_addr  = imem_addr;
                last_wdata = imem_wdata;
                if (ea.size() == 0) begin
                    check("unexpected_write", {54'd0, imem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("write_addr", {54'd0, imem_addr}, {54'd0, ea.pop_front()});
                    check("write_data", {32'd0, imem_wdata}, {32'd0, ed.pop_front()});
                end
            end
        end
    end

    task automatic do_reset();
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        exp_rdy  = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_cr   = 1'b1;
        ea.delete();
        ed.delete();
        chk_en   = 1'b1;
        check("rst_we", {63'd0, imem_we}, 64'd0);
        check("rst_addr", {54'd0, imem_addr}, 64'd0);
        check("rst_wdata", {32'd0, imem_wdata}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_rdy = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(posedge clk);
                #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic build(input logic [15:0] n, input logic [7:0] bad);
        logic [7:0] s;
        s = 8'd0;
        frm.delete();
        frm.push_back(8'hA5);
        frm.push_back(n[7:0]);
        frm.push_back(n[15:8]);
        foreach (wq[i]) begin
            for (int b = 0; b < 4; b++) begin
                frm.push_back(wq[i][8*b +: 8]);
                s = s + wq[i][8*b +: 8];
            end
        end
        frm.push_back(s + bad);
    endtask

    // Expected effects are derived from the frame as a whole; only the first `limit` bytes are sent.
    task automatic send_frame(input int limit);
        int         n, ci;
        logic [7:0] s;
        n  = {frm[2], frm[1]};
        ci = 3 + 4 * n;
        s  = 8'd0;
        if (n <= CAP) begin
            for (int k = 0; k < n; k++) begin
                if (3 + 4 * k + 4 <= limit) begin
                    ea.push_back(AW'(k));
                    ed.push_back({frm[3+4*k+3], frm[3+4*k+2], frm[3+4*k+1], frm[3+4*k]});
                end
            end
            for (int i = 3; i < ci; i++) s = s + frm[i];
        end
        for (int i = 0; i < limit; i++) begin
            send_byte(frm[i]);
            if (i == 0) begin
                exp_done = 1'b0;
                exp_err  = 1'b0;
                exp_cr   = 1'b1;
            end
            if (n > CAP && i == 2) begin
                exp_err = 1'b1;
                exp_cr  = 1'b1;
            end
            if (n <= CAP && i == ci) begin
                exp_done = (frm[i] == s);
                exp_err  = (frm[i] != s);
                exp_cr   = (frm[i] != s);
            end
        end
        if (limit >= frm.size()) begin
            repeat (2) @(posedge clk);
            #1;
            check("pending_writes", 64'(ea.size()), 64'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, nn;
        rx_data  = 8'd0;
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // branch program preceded by junk bytes
        send_byte(8'h3C);
        send_byte(8'h12);
        wq = '{32'h50000117, 32'h50010113, 32'h00200313, 32'hfff30313, 32'hfe031ee3, 32'h0000006f};
        w0 = wr_cnt;
        build(16'd6, 8'd0);
        send_frame(frm.size());
        check("branch_writes", 64'(wr_cnt - w0), 64'd6);
        check("branch_last_addr", {54'd0, last_addr}, 64'd5);
        check("branch_last_data", {32'd0, last_wdata}, 64'h0000006f);
        check("branch_done", {62'd0, done, core_reset}, 64'd2);

        // single word: A5 01 00 6F 00 00 00 6F, then bad CSUM 70
        wq = '{32'h0000006f};
        build(16'd1, 8'd0);
        check("csum_byte", {56'd0, frm[7]}, 64'h6f);
        send_frame(frm.size());
        check("csum_good_done", {63'd0, done}, 64'd1);
        build(16'd1, 8'd1);
        send_frame(frm.size());
        check("csum_bad_err", {62'd0, error, core_reset}, 64'd3);

        // empty frame
        wq.delete();
        w0 = wr_cnt;
        build(16'd0, 8'd0);
        send_frame(frm.size());
        check("empty_done", {63'd0, done}, 64'd1);
        check("empty_writes", 64'(wr_cnt - w0), 64'd0);

        // oversize length A5 01 04
        w0 = wr_cnt;
        build(16'h0401, 8'd0);
        send_frame(3);
        @(negedge clk);
        check("oversize_err", {62'd0, error, core_reset}, 64'd3);
        check("oversize_writes", 64'(wr_cnt - w0), 64'd0);

        // reset after two words of a six-word frame, then a full reload
        wq = '{32'h50000117, 32'h50010113, 32'h00200313, 32'hfff30313, 32'hfe031ee3, 32'h0000006f};
        build(16'd6, 8'd0);
        send_frame(3 + 8);
        do_reset();
        check("midrst_done", {62'd0, done, error}, 64'd0);
        gaps = 1'b1;
        send_frame(frm.size());
        check("after_rst_last_addr", {54'd0, last_addr}, 64'd5);

        // random reloads with random gaps and occasional bad checksums
        for (int f = 0; f < 8; f++) begin
            nn = $urandom_range(1, 12);
            wq.delete();
            for (int i = 0; i < nn; i++) wq.push_back($urandom);
            gaps = 1'($urandom_range(0, 1));
            build(16'(nn), ($urandom_range(0, 3) == 0) ? 8'(1 + $urandom_range(0, 254)) : 8'd0);
            send_frame(frm.size());
        end

        // exactly full memory
        wq.delete();
        for (int i = 0; i < CAP; i++) wq.push_back($urandom);
        gaps = 1'b0;
        build(16'(CAP), 8'd0);
        send_frame(frm.size());
        check("full_last_addr", {54'd0, last_addr}, 64'(CAP - 1));
        check("full_done", {62'd0, done, core_reset}, 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
